// File: rtl/nbit_mosi_spi_buffer_combined_pkg.sv
// Shared types and sizing helpers for the buffered SSD1331 MOSI master.
package nbit_mosi_spi_buffer_combined_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int N_DEF     = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int bit_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int word_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/nbit_mosi_spi_buffer_combined_shifter.sv
// One-word MSB-first shifter with its D/C bit and a final-bit flag.
module mosi_byte_shifter
    import nbit_mosi_spi_buffer_combined_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] word_in,
    input  logic             dc_in,
    output logic             mosi,
    output logic             dc,
    output logic             final_bit
);

    localparam int BIT_W = bit_cnt_w(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic             dc_q;
    logic             active;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            dc_q    <= 1'b0;
            active  <= 1'b0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
            dc_q    <= 1'b0;
            active  <= 1'b0;
        end else if (load) begin
            shreg   <= word_in;
            bit_cnt <= BIT_W'(WIDTH - 1);
            dc_q    <= dc_in;
            active  <= 1'b1;
        end else if (shift_en) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - BIT_W'(1);
        end
    end

    assign mosi      = shreg[WIDTH-1];
    assign dc        = dc_q;
    assign final_bit = active && (bit_cnt == '0);

endmodule

// File: rtl/nbit_mosi_spi_buffer_combined.sv
// Buffered write-only SPI master: latches up to N words with D/C flags and
// streams them MSB-first, reloading seamlessly on back-to-back requests.
module nbit_mosi_spi_buffer_combined
    import nbit_mosi_spi_buffer_combined_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N     = N_DEF
) (
    input  logic               i_SCK,
    input  logic               i_RST,
    input  logic [WIDTH*N-1:0] i_DATA,
    input  logic [N-1:0]       i_DC,
    input  logic               i_START,
    input  logic [4:0]         i_N_transmit,
    output logic               o_MOSI,
    output logic               o_CS,
    output logic               o_DC,
    output logic               o_MOSI_FINAL_BIT,
    output logic               o_MOSI_FINAL_BYTE,
    output state_t             o_state
);

    localparam int WORD_W = word_cnt_w(N);

    state_t              state, state_next;
    logic [WIDTH*N-1:0]  buf_data;
    logic [N-1:0]        buf_dc;
    logic [WORD_W-1:0]   word_idx;
    logic [WORD_W-1:0]   count;

    logic                start_ok;
    logic                last_word;
    logic                final_bit;
    logic                load_in;
    logic                advance;
    logic                shift_en;
    logic                clear;
    logic [4:0]          n_clamped;
    logic [WORD_W-1:0]   next_idx;
    logic [WIDTH*N-1:0]  data_sh;
    logic [N-1:0]        dc_sh;
    logic [WIDTH-1:0]    sh_word;
    logic                sh_dc;

    // Handshake: i_START is a level request with no ready. It is accepted
    // at a falling edge while IDLE, or at the edge ending a frame's final
    // bit; a nonzero i_N_transmit is required for acceptance.
    assign start_ok  = i_START && (i_N_transmit != 5'd0);
    assign last_word = (word_idx == (count - WORD_W'(1)));
    assign n_clamped = (i_N_transmit > 5'(N)) ? 5'(N) : i_N_transmit;
    assign next_idx  = word_idx + WORD_W'(1);
    assign data_sh   = buf_data >> (WIDTH * next_idx);
    assign dc_sh     = buf_dc >> next_idx;

    always_ff @(negedge i_SCK or negedge i_RST) begin
        if (!i_RST) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_in    = 1'b0;
        advance    = 1'b0;
        shift_en   = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    load_in    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!final_bit) begin
                    shift_en = 1'b1;
                end else if (!last_word) begin
                    advance = 1'b1;
                end else if (start_ok) begin
                    load_in = 1'b1;
                end else begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge i_SCK or negedge i_RST) begin
        if (!i_RST) begin
            buf_data <= '0;
            buf_dc   <= '0;
            word_idx <= '0;
            count    <= '0;
        end else if (load_in) begin
            buf_data <= i_DATA;
            buf_dc   <= i_DC;
            word_idx <= '0;
            count    <= WORD_W'(n_clamped);
        end else if (advance) begin
            word_idx <= next_idx;
        end else if (clear) begin
            word_idx <= '0;
            count    <= '0;
        end
    end

    // A fresh load takes word 0 straight from the inputs for zero latency.
    assign sh_word = load_in ? i_DATA[WIDTH-1:0] : data_sh[WIDTH-1:0];
    assign sh_dc   = load_in ? i_DC[0] : dc_sh[0];

    mosi_byte_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (i_SCK),
        .rst_n     (i_RST),
        .load      (load_in | advance),
        .shift_en  (shift_en),
        .clear     (clear),
        .word_in   (sh_word),
        .dc_in     (sh_dc),
        .mosi      (o_MOSI),
        .dc        (o_DC),
        .final_bit (final_bit)
    );

    assign o_CS              = (state == IDLE);
    assign o_MOSI_FINAL_BIT  = final_bit;
    assign o_MOSI_FINAL_BYTE = final_bit && last_word && (state == SHIFT);
    assign o_state           = state;

endmodule

// File: tb/tb_nbit_mosi_spi_buffer_combined.sv
// Directed bench: frame table streamed against a per-bit expected queue.
module tb_nbit_mosi_spi_buffer_combined;
    import nbit_mosi_spi_buffer_combined_pkg::*;

    localparam logic [4:0] IDLE_V = 5'b10000; // {cs, mosi, dc, fbit, fbyte}

    typedef struct {
        logic [63:0] data;
        logic [7:0]  dc;
        logic [4:0]  n_tx;
        int          exp_words;
    } frame_t;

    logic        i_SCK = 1'b0;
    logic        i_RST;
    logic [63:0] i_DATA;
    logic [7:0]  i_DC;
    logic        i_START;
    logic [4:0]  i_N_transmit;
    logic        o_MOSI, o_CS, o_DC, o_MOSI_FINAL_BIT, o_MOSI_FINAL_BYTE;
    state_t      state_dbg;

    logic [4:0]  exp_q[$];
    frame_t      tbl[0:9];
    int          n_checks = 0;
    int          n_fail   = 0;

    nbit_mosi_spi_buffer_combined #(.WIDTH(8), .N(8)) dut (
        .i_SCK             (i_SCK),
        .i_RST             (i_RST),
        .i_DATA            (i_DATA),
        .i_DC              (i_DC),
        .i_START           (i_START),
        .i_N_transmit      (i_N_transmit),
        .o_MOSI            (o_MOSI),
        .o_CS              (o_CS),
        .o_DC              (o_DC),
        .o_MOSI_FINAL_BIT  (o_MOSI_FINAL_BIT),
        .o_MOSI_FINAL_BYTE (o_MOSI_FINAL_BYTE),
        .o_state           (state_dbg)
    );

    always #5 i_SCK = ~i_SCK;

    task automatic check_out(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {o_CS, o_MOSI, o_DC, o_MOSI_FINAL_BIT, o_MOSI_FINAL_BYTE};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {cs,mosi,dc,fbit,fbyte}=%b expected %b at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string name, input state_t exp);
        n_checks++;
        if (state_dbg !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d expected %0d", name, state_dbg, exp);
        end
    endtask

    task automatic sample();
        @(posedge i_SCK);
        #1;
    endtask

    task automatic drive(input frame_t f);
        i_DATA       = f.data;
        i_DC         = f.dc;
        i_N_transmit = f.n_tx;
        i_START      = 1'b1;
    endtask

    task automatic push_frame(input frame_t f);
        logic [63:0] d;
        d = f.data;
        for (int k = 0; k < f.exp_words; k++) begin
            for (int b = 7; b >= 0; b--) begin
                exp_q.push_back({1'b0, d[8*k+b], f.dc[k], (b == 0),
                                 (b == 0) && (k == f.exp_words - 1)});
            end
        end
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            check_out(name, IDLE_V);
        end
    endtask

    // Frames first..last are requested back to back; the next request is
    // presented during the final bit of the current frame.
    task automatic run_stream(input string name, input int first, input int last);
        logic [4:0] e;
        int cur;
        for (int f = first; f <= last; f++) push_frame(tbl[f]);
        drive(tbl[first]);
        cur = first;
        while (exp_q.size() > 0) begin
            sample();
            e = exp_q.pop_front();
            check_out(name, e);
            if (e[0]) begin
                cur++;
                if (cur <= last) drive(tbl[cur]);
                else i_START = 1'b0;
            end
        end
        sample();
        check_out({name, "_end_idle"}, IDLE_V);
    endtask

    initial begin
        tbl[0] = '{64'h7FBFDFEFF7FBFDFE, 8'b10101010, 5'd8,  8};
        tbl[1] = '{64'h00000000C0300C03, 8'b00001100, 5'd4,  4};
        tbl[2] = '{64'h000000000000FF00, 8'b00000010, 5'd2,  2};
        tbl[3] = '{64'hFFFFFFFFFFFFFF00, 8'b11111110, 5'd1,  1};
        tbl[4] = '{64'h00000000000000FF, 8'b00000000, 5'd1,  1};
        tbl[5] = '{64'hFFFFFFFFFFFFFF00, 8'b11111110, 5'd1,  1};
        tbl[6] = '{64'h00000000000000FF, 8'b00000000, 5'd1,  1};
        tbl[7] = '{64'h0123456789ABCDEF, 8'hF0,       5'd20, 8};
        tbl[8] = '{64'h00000000000000A5, 8'b00000001, 5'd1,  1};
        tbl[9] = '{64'h0000000000003C5A, 8'b00000010, 5'd2,  2};

        i_RST        = 1'b0;
        i_DATA       = '0;
        i_DC         = '0;
        i_START      = 1'b0;
        i_N_transmit = '0;
        idle_cycles("reset_hold", 3);
        check_state("reset_state", IDLE);
        i_RST = 1'b1;
        idle_cycles("post_reset_idle", 5);

        run_stream("full_then_b2b", 0, 1);

        idle_cycles("idle_gap", 30);
        run_stream("single_word_frames", 2, 6);

        i_DATA       = 64'hFFFFFFFFFFFFFFFF;
        i_DC         = 8'hFF;
        i_N_transmit = 5'd0;
        i_START      = 1'b1;
        idle_cycles("n_zero_ignored", 6);
        check_state("n_zero_state", IDLE);
        i_START = 1'b0;

        run_stream("n_clamped", 7, 7);

        drive(tbl[0]);
        sample();
        check_out("abort_bit7", 5'b01000);
        sample();
        check_out("abort_bit6", 5'b01000);
        i_START = 1'b0;
        #2;
        i_RST = 1'b0;
        #1;
        check_out("abort_async", IDLE_V);
        check_state("abort_state", IDLE);
        idle_cycles("abort_hold", 2);
        i_RST = 1'b1;
        idle_cycles("abort_release", 2);
        run_stream("after_abort", 8, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
